lcd_refresh_ctrl: RTL

LCD_REFRESH_CTRL -- requirements
Module: lcd_refresh_ctrl

---
 rtl/lcd_refresh_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lcd_refresh_ctrl.sv
// Character-LCD frame refresher: 2 address commands plus 32 data writes per frame, optional power-up init (LCD_INIT_EN).
// Latency: write strobes are spaced by E_PW high and WAIT_CYC/CLR_WAIT_CYC hold; no backpressure (refresh_en is sampled only between frames).
module lcd_refresh_ctrl #(
  parameter int E_PW         = 12,
  parameter int WAIT_CYC     = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh_en,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       frame_done
);

  localparam int MAX_A   = (CLR_WAIT_CYC > WAIT_CYC) ? CLR_WAIT_CYC : WAIT_CYC;
  localparam int MAX_CYC = (MAX_A > E_PW) ? MAX_A : E_PW;
  localparam int CW_RAW  = $clog2(MAX_CYC + 1);
  localparam int CW      = (CW_RAW < 2) ? 2 : CW_RAW;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SET_ADDR = 3'd1;
  localparam logic [2:0] FETCH    = 3'd2;
  localparam logic [2:0] SETUP    = 3'd3;
  localparam logic [2:0] E_HIGH   = 3'd4;
  localparam logic [2:0] HOLD     = 3'd5;
  localparam logic [2:0] NEXT     = 3'd6;
`ifdef LCD_INIT_EN
  localparam logic [2:0] INIT      = 3'd7;
  localparam logic [2:0] RST_STATE = INIT;
`else
  localparam logic [2:0] RST_STATE = IDLE;
`endif

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hold_last;
  logic          e_done;
  logic          hold_done;
  logic          fetch_done;
  logic          timed_state;

  assign lcd_rw = 1'b0;

  // Clear-display needs the long settle time; rs/data are frozen through HOLD so they identify it.
  assign hold_last   = (!lcd_rs && lcd_data == 8'h01) ? CW'(CLR_WAIT_CYC - 1) : CW'(WAIT_CYC - 1);
  assign e_done      = (cnt == CW'(E_PW - 1));
  assign hold_done   = (cnt == hold_last);
  assign fetch_done  = (cnt == CW'(2));
  assign timed_state = (state == FETCH) || (state == E_HIGH) || (state == HOLD);

`ifdef LCD_INIT_EN
  logic       in_init;
  logic [1:0] init_step;
  logic [7:0] init_cmd;

  always_comb begin
    init_cmd = 8'h38;
    case (init_step)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_init   <= 1'b1;
      init_step <= 2'd0;
    end else if (state == HOLD && hold_done && in_init) begin
      if (init_step == 2'd3) begin
        in_init <= 1'b0;
      end else begin
        init_step <= init_step + 2'd1;
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (refresh_en) state_nxt = SET_ADDR;
`ifdef LCD_INIT_EN
      INIT:     state_nxt = SETUP;
`endif
      SET_ADDR: state_nxt = SETUP;
      FETCH:    if (fetch_done) state_nxt = SETUP;
      SETUP:    state_nxt = E_HIGH;
      E_HIGH:   if (e_done) state_nxt = HOLD;
      HOLD: begin
        if (hold_done) begin
          if (lcd_rs) state_nxt = NEXT;
          else        state_nxt = FETCH;
`ifdef LCD_INIT_EN
          if (in_init) state_nxt = (init_step == 2'd3) ? IDLE : INIT;
`endif
        end
      end
      NEXT: begin
        if (index == 5'd15)      state_nxt = SET_ADDR;
        else if (index == 5'd31) state_nxt = refresh_en ? SET_ADDR : IDLE;
        else                     state_nxt = FETCH;
      end
      default:  state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RST_STATE;
      cnt        <= '0;
      index      <= 5'd0;
      lcd_rs     <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_data   <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= 1'b0;

      if (state_nxt != state) cnt <= '0;
      else if (timed_state)   cnt <= cnt + CW'(1);

      case (state)
        IDLE: if (refresh_en) index <= 5'd0;
`ifdef LCD_INIT_EN
        INIT: begin
          lcd_rs   <= 1'b0;
          lcd_data <= init_cmd;
        end
`endif
        SET_ADDR: begin
          lcd_rs   <= 1'b0;
          lcd_data <= index[4] ? 8'hC0 : 8'h80;
        end
        // char_in lags index by one registered cycle; sampling on the 3rd FETCH cycle leaves margin.
        FETCH: begin
          if (fetch_done) begin
            lcd_rs   <= 1'b1;
            lcd_data <= char_in;
          end
        end
        SETUP:  lcd_e <= 1'b1;
        E_HIGH: if (e_done) lcd_e <= 1'b0;
        NEXT: begin
          if (index == 5'd31) begin
            index      <= 5'd0;
            frame_done <= 1'b1;
          end else begin
            index <= index + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
